// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared state enum, size codes and timeout default for the bus initiator
package bus_pkg;

    typedef enum logic [2:0] {IDLE, ARB, S0, S1, S2, WAIT, NEG, RECOV} bus_state_t;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;

    localparam int TIMEOUT_CYCLES_DEFAULT = 255;

    // Returns {UDS, LDS}; the even byte of a word lives on the upper lane.
    function automatic logic [1:0] lane_strobes(input logic size, input logic a0);
        if (size == SIZE_WORD) return 2'b11;
        return a0 ? 2'b01 : 2'b10;
    endfunction

endpackage

// File: rtl/bus_initiator_if.sv
// rtl/bus_initiator_if.sv - requester handshake plus asynchronous bus signals
interface bus_initiator_if;

    logic        REQ_IN;
    logic        REQ_RW_IN;
    logic        REQ_SIZE_IN;
    logic [23:0] REQ_ADDR_IN;
    logic [15:0] REQ_WDATA_IN;
    logic        BUSY;
    logic        DONE;
    logic        ERR;
    logic [15:0] RDATA;
    logic        BR;
    logic        BGACK;
    logic        BG_IN;
    logic        AS;
    logic        UDS;
    logic        LDS;
    logic        RW;
    logic [23:0] ADDR;
    logic [15:0] DATA_OUT;
    logic        DATA_OE;
    logic [15:0] DATA_IN;
    logic        DTACK_IN;

    modport master (
        input  REQ_IN, REQ_RW_IN, REQ_SIZE_IN, REQ_ADDR_IN, REQ_WDATA_IN,
        input  BG_IN, DATA_IN, DTACK_IN,
        output BUSY, DONE, ERR, RDATA, BR, BGACK, AS, UDS, LDS, RW,
        output ADDR, DATA_OUT, DATA_OE
    );

    modport slave (
        output REQ_IN, REQ_RW_IN, REQ_SIZE_IN, REQ_ADDR_IN, REQ_WDATA_IN,
        output BG_IN, DATA_IN, DTACK_IN,
        input  BUSY, DONE, ERR, RDATA, BR, BGACK, AS, UDS, LDS, RW,
        input  ADDR, DATA_OUT, DATA_OE
    );

endinterface

// File: rtl/bus_timeout.sv
// rtl/bus_timeout.sv - cycle counter that flags expiry after LIMIT enabled cycles
module bus_timeout #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!resetn || clear) count <= '0;
        else if (enable && !expire) count <= count + 1'b1;
    end

    // Count starts at 0 on the first enabled cycle, so LIMIT-1 marks the last one.
    assign expire = (count == W'(LIMIT - 1));

endmodule

// File: rtl/bus_initiator.sv
// rtl/bus_initiator.sv - 68000-style single-cycle bus master; BUS_TIMEOUT_EN adds DTACK timeout
module bus_initiator
    import bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
)
(
    input logic             CPUCLK_IN,
    input logic             RESET_N_IN,
    bus_initiator_if.master bus
);

    bus_state_t  state, state_n;
    logic        req_rw, req_rw_n, req_size, req_size_n;
    logic [23:0] req_addr, req_addr_n;
    logic [15:0] req_wdata, req_wdata_n;
    logic        busy, busy_n, done, done_n, err, err_n, err_flag, err_flag_n;
    logic [15:0] rdata, rdata_n;
    logic        br, br_n, bgack, bgack_n, as_q, as_n, uds, uds_n, lds, lds_n;
    logic        rw, rw_n, data_oe, data_oe_n;
    logic [23:0] addr, addr_n;
    logic [15:0] data_out, data_out_n;
    logic [1:0]  lanes;
    logic        tmo_expired;

    assign lanes = lane_strobes(req_size, req_addr[0]);

`ifdef BUS_TIMEOUT_EN
    logic tmo_run;
    assign tmo_run = (state == WAIT) || (state == RECOV);

    bus_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk    (CPUCLK_IN),
        .resetn (RESET_N_IN),
        .clear  (!tmo_run),
        .enable (tmo_run),
        .expire (tmo_expired)
    );
`else
    assign tmo_expired = 1'b0;
`endif

    // Outputs are registered alongside the state so each appears in the cycle of its state.
    always_comb begin
        state_n     = state;
        req_rw_n    = req_rw;
        req_size_n  = req_size;
        req_addr_n  = req_addr;
        req_wdata_n = req_wdata;
        busy_n      = busy;
        done_n      = 1'b0;
        err_n       = 1'b0;
        err_flag_n  = err_flag;
        rdata_n     = rdata;
        br_n        = br;
        bgack_n     = bgack;
        as_n        = as_q;
        uds_n       = uds;
        lds_n       = lds;
        rw_n        = rw;
        addr_n      = addr;
        data_out_n  = data_out;
        data_oe_n   = data_oe;
        case (state)
            IDLE: begin
                if (busy) begin
                    done_n = 1'b1;
                    err_n  = 1'b1;
                    busy_n = 1'b0;
                end else if (bus.REQ_IN) begin
                    req_rw_n    = bus.REQ_RW_IN;
                    req_size_n  = bus.REQ_SIZE_IN;
                    req_addr_n  = bus.REQ_ADDR_IN;
                    req_wdata_n = bus.REQ_WDATA_IN;
                    busy_n      = 1'b1;
                    err_flag_n  = 1'b0;
                    if (!(bus.REQ_SIZE_IN == SIZE_WORD && bus.REQ_ADDR_IN[0])) begin
                        state_n = ARB;
                        br_n    = 1'b1;
                    end
                end
            end
            ARB: begin
                if (bus.BG_IN && !bus.DTACK_IN) begin
                    state_n = S0;
                    br_n    = 1'b0;
                    bgack_n = 1'b1;
                    addr_n  = req_addr;
                    rw_n    = req_rw;
                    if (!req_rw) begin
                        data_out_n = (req_size == SIZE_BYTE) ? {2{req_wdata[7:0]}} : req_wdata;
                        data_oe_n  = 1'b1;
                    end
                end
            end
            S0: begin
                state_n = S1;
                as_n    = 1'b1;
                if (req_rw) {uds_n, lds_n} = lanes;
            end
            S1: begin
                state_n = req_rw ? WAIT : S2;
                if (!req_rw) {uds_n, lds_n} = lanes;
            end
            S2: state_n = WAIT;
            WAIT: begin
                if (bus.DTACK_IN || tmo_expired) begin
                    state_n = NEG;
                    as_n    = 1'b0;
                    uds_n   = 1'b0;
                    lds_n   = 1'b0;
                    if (!bus.DTACK_IN) err_flag_n = 1'b1;
                    else if (req_rw) begin
                        if (req_size == SIZE_WORD) rdata_n = bus.DATA_IN;
                        else rdata_n = {8'h00, req_addr[0] ? bus.DATA_IN[7:0] : bus.DATA_IN[15:8]};
                    end
                end
            end
            NEG: state_n = RECOV;
            RECOV: begin
                if (!bus.DTACK_IN || tmo_expired) begin
                    state_n    = IDLE;
                    bgack_n    = 1'b0;
                    data_oe_n  = 1'b0;
                    addr_n     = '0;
                    rw_n       = 1'b0;
                    data_out_n = '0;
                    done_n     = 1'b1;
                    err_n      = err_flag || bus.DTACK_IN;
                    busy_n     = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CPUCLK_IN) begin
        if (!RESET_N_IN) begin
            state     <= IDLE;
            req_rw    <= 1'b0;
            req_size  <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_flag  <= 1'b0;
            rdata     <= '0;
            br        <= 1'b0;
            bgack     <= 1'b0;
            as_q      <= 1'b0;
            uds       <= 1'b0;
            lds       <= 1'b0;
            rw        <= 1'b0;
            addr      <= '0;
            data_out  <= '0;
            data_oe   <= 1'b0;
        end else begin
            state     <= state_n;
            req_rw    <= req_rw_n;
            req_size  <= req_size_n;
            req_addr  <= req_addr_n;
            req_wdata <= req_wdata_n;
            busy      <= busy_n;
            done      <= done_n;
            err       <= err_n;
            err_flag  <= err_flag_n;
            rdata     <= rdata_n;
            br        <= br_n;
            bgack     <= bgack_n;
            as_q      <= as_n;
            uds       <= uds_n;
            lds       <= lds_n;
            rw        <= rw_n;
            addr      <= addr_n;
            data_out  <= data_out_n;
            data_oe   <= data_oe_n;
        end
    end

    assign bus.BUSY     = busy;
    assign bus.DONE     = done;
    assign bus.ERR      = err;
    assign bus.RDATA    = rdata;
    assign bus.BR       = br;
    assign bus.BGACK    = bgack;
    assign bus.AS       = as_q;
    assign bus.UDS      = uds;
    assign bus.LDS      = lds;
    assign bus.RW       = rw;
    assign bus.ADDR     = addr;
    assign bus.DATA_OUT = data_out;
    assign bus.DATA_OE  = data_oe;

endmodule

// File: tb/tb_bus_initiator.sv
// tb/tb_bus_initiator.sv - directed bench for bus_initiator with arbiter/responder models
module tb_bus_initiator;
    import bus_pkg::*;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    bus_initiator_if bif ();

    bus_initiator #(.TIMEOUT_CYCLES(16)) dut (
        .CPUCLK_IN  (clk),
        .RESET_N_IN (rstn),
        .bus        (bif)
    );

    int   checks = 0;
    int   errors = 0;
    int   g_dly = 0;
    int   d_dly = 0;
    logic dtack_never = 1'b0;
    int   gcnt, dcnt;

    // Arbiter: grants g_dly cycles after BR is first seen.
    always @(posedge clk) begin
        if (!rstn || !bif.BR) begin
            gcnt       <= 0;
            bif.BG_IN  <= 1'b0;
        end else if (gcnt >= g_dly) bif.BG_IN <= 1'b1;
        else gcnt <= gcnt + 1;
    end

    // Responder: DTACK d_dly cycles after strobes are first seen, dropped once they go.
    always @(posedge clk) begin
        if (!rstn || dtack_never || !(bif.AS && (bif.UDS || bif.LDS))) begin
            dcnt         <= 0;
            bif.DTACK_IN <= 1'b0;
        end else if (dcnt >= d_dly) bif.DTACK_IN <= 1'b1;
        else dcnt <= dcnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
        end
    endtask

    int as_cyc, strb_cyc, strb_end, done_cyc, dones, br_cycles;
    logic [31:0] r_err, r_rdata, r_dout, r_dout3, r_lanes, r_addr, r_rw, r_oe;
    logic [31:0] r_busy0, r_busy_done, r_bgack_done;

    task automatic run_req(input logic rw, input logic size, input logic [23:0] a,
                           input logic [15:0] wd, input int repulse);
        as_cyc = -1; strb_cyc = -1; strb_end = -1; done_cyc = -1; dones = 0; br_cycles = 0;
        r_dout3 = '0;
        @(negedge clk);
        bif.REQ_RW_IN    = rw;
        bif.REQ_SIZE_IN  = size;
        bif.REQ_ADDR_IN  = a;
        bif.REQ_WDATA_IN = wd;
        bif.REQ_IN       = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            bif.REQ_IN = (c == repulse);
            if (c == repulse) begin
                bif.REQ_ADDR_IN = 24'h000301;
                bif.REQ_SIZE_IN = SIZE_WORD;
            end
            if (c == 0) r_busy0 = bif.BUSY;
            if (c == 3) r_dout3 = bif.DATA_OUT;
            if (bif.BR) br_cycles++;
            if (bif.AS && as_cyc < 0) begin
                as_cyc = c; r_addr = bif.ADDR; r_rw = bif.RW;
            end
            if ((bif.UDS || bif.LDS) && strb_cyc < 0) begin
                strb_cyc = c; r_lanes = {bif.UDS, bif.LDS}; r_dout = bif.DATA_OUT; r_oe = bif.DATA_OE;
            end
            if (strb_cyc >= 0 && strb_end < 0 && !(bif.UDS || bif.LDS)) strb_end = c;
            if (bif.DONE) begin
                dones++;
                if (done_cyc < 0) begin
                    done_cyc = c; r_err = bif.ERR; r_rdata = bif.RDATA;
                    r_busy_done = bif.BUSY; r_bgack_done = bif.BGACK;
                end
            end
            if (done_cyc >= 0 && c >= done_cyc + 3) break;
        end
        bif.REQ_IN = 1'b0;
    endtask

    initial begin
        bif.REQ_IN = 1'b0; bif.REQ_RW_IN = 1'b0; bif.REQ_SIZE_IN = 1'b0;
        bif.REQ_ADDR_IN = '0; bif.REQ_WDATA_IN = '0; bif.DATA_IN = 16'hBEEF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", bif.BUSY, 0);
        check("rst_br", bif.BR, 0);
        check("rst_as", bif.AS, 0);
        check("rst_addr", bif.ADDR, 0);
        check("rst_rdata", bif.RDATA, 0);
        rstn = 1'b1;

        run_req(1'b1, SIZE_WORD, 24'h000100, 16'h0000, -1);
        check("wr_as_cyc", as_cyc, 3);
        check("wr_strb_cyc", strb_cyc, 3);
        check("wr_lanes", r_lanes, 2'b11);
        check("wr_addr", r_addr, 24'h000100);
        check("wr_rw", r_rw, 1);
        check("wr_done_cyc", done_cyc, 7);
        check("wr_rdata", r_rdata, 16'hBEEF);
        check("wr_err", r_err, 0);
        check("wr_dones", dones, 1);
        check("wr_br_cycles", br_cycles, 2);
        check("wr_busy0", r_busy0, 1);
        check("wr_busy_done", r_busy_done, 0);
        check("wr_bgack_done", r_bgack_done, 0);

        bif.DATA_IN = 16'hA55A;
        run_req(1'b1, SIZE_BYTE, 24'h000200, 16'h0000, -1);
        check("br_even_lanes", r_lanes, 2'b10);
        check("br_even_rdata", r_rdata, 16'h00A5);
        check("br_even_done", done_cyc, 7);
        run_req(1'b1, SIZE_BYTE, 24'h000201, 16'h0000, -1);
        check("br_odd_lanes", r_lanes, 2'b01);
        check("br_odd_rdata", r_rdata, 16'h005A);

        d_dly = 4;
        run_req(1'b0, SIZE_BYTE, 24'h100003, 16'h345A, -1);
        d_dly = 0;
        check("bw_as_cyc", as_cyc, 3);
        check("bw_strb_cyc", strb_cyc, 4);
        check("bw_lanes", r_lanes, 2'b01);
        check("bw_dout", r_dout, 16'h5A5A);
        check("bw_dout_pre", r_dout3, 16'h5A5A);
        check("bw_oe", r_oe, 1);
        check("bw_rw", r_rw, 0);
        check("bw_addr", r_addr, 24'h100003);
        check("bw_strb_end", strb_end, 10);
        check("bw_done_cyc", done_cyc, 12);
        check("bw_err", r_err, 0);

        run_req(1'b1, SIZE_WORD, 24'h000101, 16'h0000, -1);
        check("mis_done_cyc", done_cyc, 1);
        check("mis_err", r_err, 1);
        check("mis_br_cycles", br_cycles, 0);
        check("mis_as_cyc", as_cyc, 32'hFFFF_FFFF);
        check("mis_dones", dones, 1);

        g_dly = 10;
        bif.DATA_IN = 16'h1357;
        run_req(1'b1, SIZE_WORD, 24'h000500, 16'h0000, 5);
        g_dly = 0;
        check("bg_br_cycles", br_cycles, 12);
        check("bg_dones", dones, 1);
        check("bg_done_cyc", done_cyc, 17);
        check("bg_err", r_err, 0);
        check("bg_rdata", r_rdata, 16'h1357);

        dtack_never = 1'b1;
        @(negedge clk);
        bif.REQ_RW_IN = 1'b0; bif.REQ_SIZE_IN = SIZE_WORD;
        bif.REQ_ADDR_IN = 24'h000600; bif.REQ_WDATA_IN = 16'hCAFE; bif.REQ_IN = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bif.REQ_IN = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_as", bif.AS, 1);
        rstn = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", bif.BUSY, 0);
        check("mid_rst_strobes", {bif.AS, bif.UDS, bif.LDS, bif.RW}, 0);
        check("mid_rst_bus", {bif.BR, bif.BGACK, bif.DATA_OE, bif.DONE, bif.ERR}, 0);
        check("mid_rst_addr", bif.ADDR, 0);
        check("mid_rst_dout", bif.DATA_OUT, 0);
        check("mid_rst_rdata", bif.RDATA, 0);
        rstn = 1'b1;
        dtack_never = 1'b0;
        @(negedge clk);
        bif.DATA_IN = 16'hBEEF;
        run_req(1'b1, SIZE_WORD, 24'h000100, 16'h0000, -1);
        check("post_done_cyc", done_cyc, 7);
        check("post_rdata", r_rdata, 16'hBEEF);

`ifdef BUS_TIMEOUT_EN
        dtack_never = 1'b1;
        bif.DATA_IN = 16'h1234;
        run_req(1'b1, SIZE_WORD, 24'h000400, 16'h0000, -1);
        dtack_never = 1'b0;
        check("to_strb_end", strb_end, 20);
        check("to_done_cyc", done_cyc, 22);
        check("to_err", r_err, 1);
        check("to_bgack", r_bgack_done, 0);
        check("to_rdata", r_rdata, 16'hBEEF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

endmodule
